mmio_gpio_ctrl: RTL and testbench

Parametrised memory-mapped GPIO controller on the single-cycle core's data bus. It replaces the fixed 4-bit LED and 5-switch/IR input peripherals with N_OUT outputs and N_IN inputs. Inputs are synchronised and debounced, and rising edges are captured into sticky flags with an interrupt. Loads hitting its address window get a combinational read-data override, and stores to the window are withheld from data RAM.

---
 rtl/gpio_pkg.sv | 17 +
 rtl/gpio_debounce.sv | 50 +++++
 rtl/mmio_gpio_ctrl.sv | 131 +++++++++++++
 tb/tb_mmio_gpio_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the memory-mapped GPIO controller: register offsets
// within the four-word window and a counter-width helper.
package gpio_pkg;

   localparam int REG_CNT = 4;

   localparam logic [1:0] OFF_OUT  = 2'd0;
   localparam logic [1:0] OFF_IN   = 2'd1;
   localparam logic [1:0] OFF_EDGE = 2'd2;
   localparam logic [1:0] OFF_DUTY = 2'd3;

   // Width of a counter that must hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input channel: 2-flop synchroniser, consecutive-sample debouncer
// and a one-cycle pulse on the edge where the accepted level goes 0->1.
module gpio_debounce
   import gpio_pkg::*;
#(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_pin,
   output logic o_stable,
   output logic o_rise
);

   localparam int            CW       = cnt_w(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic [CW-1:0] r_cnt;
   logic          w_accept;

   // The DEB_CYCLES-th consecutive mismatching sample flips the level.
   assign w_accept = (r_sync2 != r_stable) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_pin;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = w_accept & r_sync2;

endmodule

// File: rtl/mmio_gpio_ctrl.sv
// Memory-mapped GPIO controller: OUT/IN/EDGE/DUTY registers at BASE..BASE+3.
// Define GPIO_PWM_EN to build the DUTY register and PWM gating of pins_out.
module mmio_gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int ADDR_W     = 5,
   parameter int DATA_W     = 32,
   parameter int N_OUT      = 4,
   parameter int N_IN       = 6,
   parameter int DEB_CYCLES = 4,
   parameter int PWM_W      = 4,
   parameter int BASE       = 28
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata_in,
   output logic [DATA_W-1:0] rdata_out,
   output logic              mem_we,
   input  logic [N_IN-1:0]   pins_in,
   output logic [N_OUT-1:0]  pins_out,
   output logic              irq
);

   // One extra bit so BASE+3 never wraps in the window compare.
   localparam logic [ADDR_W:0] BASE_X = (ADDR_W+1)'(BASE);
   localparam logic [ADDR_W:0] LAST_X = (ADDR_W+1)'(BASE + REG_CNT - 1);

   logic [ADDR_W:0]   w_addr_x;
   logic [ADDR_W:0]   w_rel;
   logic [1:0]        w_off;
   logic              w_hit;
   logic              w_wr_out;
   logic              w_wr_edge;
   logic              w_wr_duty;
   logic [N_OUT-1:0]  r_out;
   logic [N_IN-1:0]   r_edge;
   logic [N_IN-1:0]   w_stable;
   logic [N_IN-1:0]   w_rise;
   logic [PWM_W-1:0]  w_duty_rd;
   logic              w_pwm_on;
   logic [DATA_W-1:0] w_rdata;
   logic              w_unused;

   assign w_addr_x  = {1'b0, addr};
   assign w_hit     = (w_addr_x >= BASE_X) && (w_addr_x <= LAST_X);
   assign w_rel     = w_addr_x - BASE_X;
   assign w_off     = w_rel[1:0];
   assign w_wr_out  = we && w_hit && (w_off == OFF_OUT);
   assign w_wr_edge = we && w_hit && (w_off == OFF_EDGE);
   assign w_wr_duty = we && w_hit && (w_off == OFF_DUTY);

   assign mem_we = we & ~w_hit;
   assign irq    = |r_edge;

   for (genvar g = 0; g < N_IN; g++) begin : g_ch
      gpio_debounce #(
         .DEB_CYCLES(DEB_CYCLES)
      ) u_deb (
         .clk     (clk),
         .reset   (reset),
         .i_pin   (pins_in[g]),
         .o_stable(w_stable[g]),
         .o_rise  (w_rise[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out <= '0;
      end else if (w_wr_out) begin
         r_out <= wdata[N_OUT-1:0];
      end
   end

   // A new rise wins over a W1C clear of the same bit in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_edge <= '0;
      end else if (w_wr_edge) begin
         r_edge <= (r_edge & ~wdata[N_IN-1:0]) | w_rise;
      end else begin
         r_edge <= r_edge | w_rise;
      end
   end

`ifdef GPIO_PWM_EN
   logic [PWM_W-1:0] r_duty;
   logic [PWM_W-1:0] r_pwm_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_duty    <= '1;
         r_pwm_cnt <= '0;
      end else begin
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
         if (w_wr_duty) begin
            r_duty <= wdata[PWM_W-1:0];
         end
      end
   end

   assign w_pwm_on  = (&r_duty) | (r_pwm_cnt < r_duty);
   assign w_duty_rd = r_duty;
`else
   assign w_pwm_on  = 1'b1;
   assign w_duty_rd = '0;
`endif

   assign pins_out = r_out & {N_OUT{w_pwm_on}};

   always_comb begin
      w_rdata = rdata_in;
      if (w_hit) begin
         w_rdata = '0;
         case (w_off)
            OFF_OUT:  w_rdata[N_OUT-1:0] = r_out;
            OFF_IN:   w_rdata[N_IN-1:0]  = w_stable;
            OFF_EDGE: w_rdata[N_IN-1:0]  = r_edge;
            default:  w_rdata[PWM_W-1:0] = w_duty_rd;
         endcase
      end
   end

   assign rdata_out = w_rdata;

   assign w_unused = &{1'b0, wdata, w_rel, w_wr_duty};

endmodule

// File: tb/tb_mmio_gpio_ctrl.sv
// Bench for mmio_gpio_ctrl: decode table, directed multi-cycle sequences and
// a randomized run checked against a history-window reference model.
module tb_mmio_gpio_ctrl;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int N_OUT  = 4;
   localparam int N_IN   = 6;
   localparam int DEB    = 4;
   localparam int PWM_W  = 4;
   localparam int BASE   = 28;
`ifdef GPIO_PWM_EN
   localparam bit PWM_EN = 1'b1;
`else
   localparam bit PWM_EN = 1'b0;
`endif
   localparam logic [31:0] DUTY_RST = PWM_EN ? 32'hF : 32'h0;

   logic              clk = 1'b0;
   logic              reset;
   logic [ADDR_W-1:0] addr;
   logic              we;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata_in;
   logic [DATA_W-1:0] rdata_out;
   logic              mem_we;
   logic [N_IN-1:0]   pins_in;
   logic [N_OUT-1:0]  pins_out;
   logic              irq;

   mmio_gpio_ctrl #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .N_OUT(N_OUT), .N_IN(N_IN),
      .DEB_CYCLES(DEB), .PWM_W(PWM_W), .BASE(BASE)
   ) dut (
      .clk(clk), .reset(reset), .addr(addr), .we(we), .wdata(wdata),
      .rdata_in(rdata_in), .rdata_out(rdata_out), .mem_we(mem_we),
      .pins_in(pins_in), .pins_out(pins_out), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_wr(input int a, input logic [31:0] d);
      addr  = ADDR_W'(a);
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd(input int a, output logic [31:0] v);
      addr = ADDR_W'(a);
      we   = 1'b0;
      #1;
      v = rdata_out;
   endtask

   task automatic reset_dut();
      reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; rdata_in = '0; pins_in = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reference model: registers as plain values; debounced level derived from
   // a history of pin samples (two-edge sync delay, DEB-long agreement window).
   logic [N_OUT-1:0] m_out;
   logic [N_IN-1:0]  m_stable;
   logic [N_IN-1:0]  m_edge;
   logic [PWM_W-1:0] m_duty;
   int               m_cyc;
   logic [N_IN-1:0]  m_hist[$];

   task automatic model_reset();
      m_out = '0; m_stable = '0; m_edge = '0; m_duty = '1; m_cyc = 0;
      m_hist.delete();
   endtask

   function automatic logic [31:0] exp_rd(input logic [ADDR_W-1:0] a, input logic [31:0] rin);
      int o;
      if (int'(a) < BASE || int'(a) > BASE + 3) return rin;
      o = int'(a) - BASE;
      if (o == 0) return 32'(m_out);
      if (o == 1) return 32'(m_stable);
      if (o == 2) return 32'(m_edge);
      return PWM_EN ? 32'(m_duty) : 32'h0;
   endfunction

   function automatic logic [N_OUT-1:0] exp_pins();
      bit on;
      on = !PWM_EN || (m_duty == '1) || ((m_cyc % (1 << PWM_W)) < int'(m_duty));
      return on ? m_out : '0;
   endfunction

   task automatic model_edge();
      logic [N_IN-1:0] rise;
      bit              hit;
      int              o;
      rise = '0;
      for (int i = 0; i < N_IN; i++) begin
         bit all_diff;
         all_diff = 1'b1;
         for (int k = 0; k < DEB; k++) begin
            int  idx;
            logic v;
            idx = m_hist.size() - 2 - k;
            v   = (idx >= 0) ? m_hist[idx][i] : 1'b0;
            if (v == m_stable[i]) all_diff = 1'b0;
         end
         if (all_diff) begin
            m_stable[i] = ~m_stable[i];
            if (m_stable[i]) rise[i] = 1'b1;
         end
      end
      hit = (int'(addr) >= BASE) && (int'(addr) <= BASE + 3);
      o   = int'(addr) - BASE;
      if (we && hit && o == 0) m_out = wdata[N_OUT-1:0];
      if (we && hit && o == 2) m_edge = m_edge & ~wdata[N_IN-1:0];
      if (we && hit && o == 3 && PWM_EN) m_duty = wdata[PWM_W-1:0];
      m_edge = m_edge | rise;
      m_hist.push_back(pins_in);
      if (m_hist.size() > DEB + 2) void'(m_hist.pop_front());
      m_cyc++;
   endtask

   typedef struct {
      logic [ADDR_W-1:0] a;
      logic              w;
      logic [31:0]       rin;
      logic [31:0]       exp_rd;
      logic              exp_mwe;
   } vec_t;

   vec_t tbl[11];

   initial begin
      logic [31:0] v;
      int          hi;
      int          other;

      tbl[0]  = '{5'd28, 1'b0, 32'h12345678, 32'h0,        1'b0};
      tbl[1]  = '{5'd29, 1'b0, 32'h12345678, 32'h0,        1'b0};
      tbl[2]  = '{5'd30, 1'b0, 32'h12345678, 32'h0,        1'b0};
      tbl[3]  = '{5'd31, 1'b0, 32'h12345678, DUTY_RST,     1'b0};
      tbl[4]  = '{5'd27, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      tbl[5]  = '{5'd5,  1'b0, 32'hCAFE0005, 32'hCAFE0005, 1'b0};
      tbl[6]  = '{5'd5,  1'b1, 32'h00000011, 32'h00000011, 1'b1};
      tbl[7]  = '{5'd0,  1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
      tbl[8]  = '{5'd30, 1'b1, 32'h00000055, 32'h0,        1'b0};
      tbl[9]  = '{5'd31, 1'b1, 32'h00000077, DUTY_RST,     1'b0};
      tbl[10] = '{5'd29, 1'b1, 32'hABCDABCD, 32'h0,        1'b0};

      // Reset state
      reset_dut();
      check("rst_pins_out", 32'(pins_out), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_mem_we", 32'(mem_we), 32'h0);
      rd(29, v); check("rst_rd_in", v, 32'h0);
      rd(31, v); check("rst_rd_duty", v, DUTY_RST);

      // Decode table: combinational read mux and RAM write suppression
      for (int i = 0; i < 11; i++) begin
         addr = tbl[i].a; we = tbl[i].w; rdata_in = tbl[i].rin; wdata = 32'h0;
         #1;
         check($sformatf("tbl%0d_rdata", i), rdata_out, tbl[i].exp_rd);
         check($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].exp_mwe));
         we = 1'b0;
         tick();
      end

      // Store OUT, then a RAM store outside the window
      addr = 5'd28; wdata = 32'hA; we = 1'b1;
      #1; check("out_wr_mem_we", 32'(mem_we), 32'h0);
      tick();
      we = 1'b0;
      check("out_pins", 32'(pins_out), 32'hA);
      addr = 5'd5; we = 1'b1; rdata_in = 32'h5A5A; wdata = 32'h33;
      #1;
      check("ram_wr_mem_we", 32'(mem_we), 32'h1);
      check("ram_rd", rdata_out, 32'h5A5A);
      we = 1'b0;
      tick();

      // Rise on ch2 lands on exactly the sixth edge
      pins_in[2] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      rd(29, v); check("ch2_in_early", v, 32'h0);
      check("ch2_irq_early", 32'(irq), 32'h0);
      tick();
      check("ch2_irq", 32'(irq), 32'h1);
      rd(29, v); check("ch2_in", v, 32'h4);
      rd(30, v); check("ch2_edge", v, 32'h4);

      // Three-cycle glitch on ch3 is filtered
      pins_in[3] = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      pins_in[3] = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rd(29, v); check("glitch_in", v, 32'h4);
      rd(30, v); check("glitch_edge", v, 32'h4);

      // W1C clear, then a clear colliding with a new rise
      bus_wr(30, 32'h4);
      check("w1c_irq", 32'(irq), 32'h0);
      pins_in[2] = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      pins_in[2] = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      bus_wr(30, 32'h4);
      rd(30, v); check("collide_edge", v, 32'h4);
      check("collide_irq", 32'(irq), 32'h1);
      bus_wr(30, 32'h4);
      rd(30, v); check("late_clr_edge", v, 32'h0);
      check("late_clr_irq", 32'(irq), 32'h0);

      // PWM duty 4/16, then 0
      bus_wr(31, 32'h4);
      bus_wr(28, 32'h1);
      hi = 0; other = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (pins_out[0]) hi++;
         if (pins_out[N_OUT-1:1] != '0) other++;
      end
      check("pwm4_high", 32'(hi), PWM_EN ? 32'd4 : 32'd16);
      check("pwm4_other", 32'(other), 32'd0);
      bus_wr(31, 32'h0);
      rd(31, v); check("duty0_rd", v, 32'h0);
      hi = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (pins_out[0]) hi++;
      end
      check("pwm0_high", 32'(hi), PWM_EN ? 32'd0 : 32'd16);

      // Reset in the middle of a pending change restarts the full delay
      pins_in[4] = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("mid_rst_pins", 32'(pins_out), 32'h0);
      for (int i = 0; i < 5; i++) tick();
      rd(29, v); check("mid_rst_in_early", v, 32'h0);
      tick();
      rd(29, v); check("mid_rst_in", v, 32'h14);
      check("mid_rst_irq", 32'(irq), 32'h1);

      // Randomized run against the reference model
      reset_dut();
      model_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) pins_in[$urandom_range(0, N_IN-1)] ^= 1'b1;
         rdata_in = $urandom;
         wdata    = $urandom;
         addr     = ($urandom_range(0, 2) != 0) ? ADDR_W'(BASE + $urandom_range(0, 3))
                                                : ADDR_W'($urandom_range(0, 31));
         we       = ($urandom_range(0, 2) == 0);
         reset    = ($urandom_range(0, 499) == 0);
         #1;
         check("rnd_rdata", rdata_out, exp_rd(addr, rdata_in));
         check("rnd_mem_we", 32'(mem_we),
               32'(we && !(int'(addr) >= BASE && int'(addr) <= BASE + 3)));
         check("rnd_pins_out", 32'(pins_out), 32'(exp_pins()));
         check("rnd_irq", 32'(irq), 32'(|m_edge));
         @(posedge clk);
         if (reset) model_reset();
         else model_edge();
         #1;
      end
      reset = 1'b0;
      we    = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
